// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Group width is fixed at 4 bits; the group count follows from the operand width.
// Group propagate/generate pairs travel between pipeline stages as one packed struct.
package cla_pkg;

   localparam int GROUP_W = 4;

   // Number of 4-bit lookahead groups for a given operand width.
   function automatic int group_count(input int width);
      return width / GROUP_W;
   endfunction

   // Group propagate / generate pair.
   typedef struct packed {
      logic p;
      logic g;
   } grp_pg_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead cell: in-group carries plus group propagate/generate.
// Latency: purely combinational.
// Backpressure: none; no state.
module cla_group4 (
   input  logic [3:0] p_i,
   input  logic [3:0] g_i,
   input  logic       cin_i,
   output logic [4:1] carry_o,
   output logic       gp_o,
   output logic       gg_o
);

   // Fully expanded lookahead equations; no ripple inside the group.
   always_comb begin
      carry_o[1] = g_i[0] | (p_i[0] & cin_i);
      carry_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & cin_i);
      carry_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                 | (p_i[2] & p_i[1] & p_i[0] & cin_i);
      carry_o[4] = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                 | (p_i[3] & p_i[2] & p_i[1] & g_i[0])
                 | (p_i[3] & p_i[2] & p_i[1] & p_i[0] & cin_i);
      gp_o       = &p_i;
      gg_o       = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                 | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with status flags.
// Latency: 2 cycles from acceptance to out_valid; throughput 1 beat/cycle, 2 beats in flight.
// Backpressure: elastic valid/ready; in_ready is combinational from out_ready, payload holds while stalled.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_i,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_o,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = group_count(WIDTH);

   generate
      if ((WIDTH % GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
         $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
      end
   endgenerate

   // ---------------- stage 1: operand prep and per-bit / per-group P,G ----------------
   logic [WIDTH-1:0]     b_eff;
   logic                 cin_eff;
   logic [WIDTH-1:0]     p_d, g_d;
   grp_pg_t [NG-1:0]     gpg_d;
   logic [NG-1:0]        gp_w, gg_w;
   logic [WIDTH-1:0]     unused_s1_carry;

   logic [WIDTH-1:0]     p_q, g_q;
   grp_pg_t [NG-1:0]     gpg_q;
   logic                 cin_q, a_msb_q, b_msb_q;
   logic                 s1_vld_q, s1_vld_d;

   // Subtraction is A + ~B + 1; the external carry-in only matters when adding.
   always_comb begin
      b_eff   = b ^ {WIDTH{sub}};
      cin_eff = sub | c_i;
      p_d     = a ^ b_eff;
      g_d     = a & b_eff;
   end

   // Group P/G come from the same lookahead cell; its carries are not needed here.
   for (genvar k = 0; k < NG; k++) begin : g_s1
      cla_group4 u_pg (
         .p_i     (p_d[GROUP_W*k +: GROUP_W]),
         .g_i     (g_d[GROUP_W*k +: GROUP_W]),
         .cin_i   (1'b0),
         .carry_o (unused_s1_carry[GROUP_W*k +: GROUP_W]),
         .gp_o    (gp_w[k]),
         .gg_o    (gg_w[k])
      );
      assign gpg_d[k].p = gp_w[k];
      assign gpg_d[k].g = gg_w[k];
   end

   // ---------------- handshake ----------------
   logic s2_load, s1_load;
   logic out_vld_q, out_vld_d;

   // Stage 2 takes stage 1 whenever its own slot is empty or being drained.
   always_comb begin
      s2_load   = s1_vld_q & (~out_vld_q | out_ready);
      in_ready  = ~s1_vld_q | s2_load;
      s1_load   = in_valid & in_ready;
      s1_vld_d  = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_vld_q);
      out_vld_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : out_vld_q);
   end

   // Stage 1 registers: loaded only on an accepted beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         p_q      <= '0;
         g_q      <= '0;
         gpg_q    <= '0;
         cin_q    <= 1'b0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         if (s1_load) begin
            p_q     <= p_d;
            g_q     <= g_d;
            gpg_q   <= gpg_d;
            cin_q   <= cin_eff;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
         end
      end
   end

   // ---------------- stage 2: group-carry lookahead, in-group carries, flags ----------------
   logic [NG-1:0]    gcarry;
   logic [WIDTH:0]   carry;
   logic [NG-1:0]    unused_s2_gp, unused_s2_gg;
   logic [WIDTH-1:0] s_d;
   logic             c_o_d, ovf_d, zero_d;

   // Carry into group k as a flat sum of products over groups below it and the carry-in.
   always_comb begin
      logic acc;
      logic prod;
      acc       = 1'b0;
      prod      = 1'b0;
      gcarry    = '0;
      gcarry[0] = cin_q;
      for (int k = 1; k < NG; k++) begin
         acc = 1'b0;
         for (int j = 0; j < k; j++) begin
            prod = gpg_q[j].g;
            for (int m = j + 1; m < k; m++) begin
               prod = prod & gpg_q[m].p;
            end
            acc = acc | prod;
         end
         prod = cin_q;
         for (int m = 0; m < k; m++) begin
            prod = prod & gpg_q[m].p;
         end
         gcarry[k] = acc | prod;
      end
   end

   assign carry[0] = cin_q;

   // Each group resolves its own bit carries from its lookahead carry-in.
   for (genvar k = 0; k < NG; k++) begin : g_s2
      cla_group4 u_c (
         .p_i     (p_q[GROUP_W*k +: GROUP_W]),
         .g_i     (g_q[GROUP_W*k +: GROUP_W]),
         .cin_i   (gcarry[k]),
         .carry_o (carry[GROUP_W*k+1 +: GROUP_W]),
         .gp_o    (unused_s2_gp[k]),
         .gg_o    (unused_s2_gg[k])
      );
   end

   // Sum and status flags; overflow when like-signed operands give an unlike-signed result.
   always_comb begin
      s_d    = p_q ^ carry[WIDTH-1:0];
      c_o_d  = carry[WIDTH];
      ovf_d  = (a_msb_q == b_msb_q) && (s_d[WIDTH-1] != a_msb_q);
      zero_d = ~|s_d;
   end

   // Output registers: payload only changes on a stage-2 load, so it holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         s         <= '0;
         c_o       <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         out_vld_q <= out_vld_d;
         if (s2_load) begin
            s    <= s_d;
            c_o  <= c_o_d;
            ovf  <= ovf_d;
            zero <= zero_d;
         end
      end
   end

   assign out_valid = out_vld_q;

endmodule
